// File: rtl/flp_pkg.sv
// Shared constants and types for the floating-point datapath.
//   FP32 field widths, exponent extremes, rounding-mode encoding.
package flp_pkg;

  localparam int FP32_EWIDTH  = 8;
  localparam int FP32_SWIDTH  = 23;
  localparam int FP32_RSWIDTH = 2;

  localparam logic [FP32_EWIDTH-1:0] FP32_EXP_MAX  = '1;  // inf/nan exponent
  localparam logic [FP32_EWIDTH-1:0] FP32_EXP_ZERO = '0;  // zero/denormal exponent

  // Only round-to-nearest-even is implemented by flp_norm_round.
  typedef enum logic [1:0] {
    RM_RNE = 2'd0
  } rmode_e;

  localparam rmode_e RMODE_DEFAULT = RM_RNE;

endpackage

// File: rtl/flp_lzc.sv
// Combinational leading-zero counter.
//   i_vec : input vector, MSB first
//   o_cnt : number of leading zeros; WIDTH when i_vec is all zero
module flp_lzc #(
  parameter int WIDTH = 26
) (
  input  logic [WIDTH-1:0]           i_vec,
  output logic [$clog2(WIDTH+1)-1:0] o_cnt
);

  localparam int CW = $clog2(WIDTH+1);

  // Scan upward; the highest set bit is the last one to write o_cnt.
  always_comb begin
    o_cnt = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++)
      if (i_vec[i]) o_cnt = CW'(WIDTH - 1 - i);
  end

endmodule

// File: rtl/flp_norm_round.sv
// Post-add normalizer and RNE rounder, 2-stage pipeline with valid/ready.
//   clk, rst          : clock, async active-high reset
//   i_valid/o_ready   : input handshake
//   i_sgn, i_sg, i_ex : sign, unnormalized significand {carry,hidden,frac,round}, biased exponent
//   o_valid/i_ready   : output handshake
//   o_sgn, o_sg, o_ex : normalized significand (hidden bit included) and exponent
//   o_of, o_uf        : overflow to infinity / underflow flushed to zero
module flp_norm_round
  import flp_pkg::*;
#(
  parameter int EWIDTH  = FP32_EWIDTH,
  parameter int SWIDTH  = FP32_SWIDTH,
  parameter int RSWIDTH = FP32_RSWIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic                        i_sgn,
  input  logic [SWIDTH+RSWIDTH+1:0]   i_sg,
  input  logic [EWIDTH-1:0]           i_ex,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic                        o_sgn,
  output logic [SWIDTH:0]             o_sg,
  output logic [EWIDTH-1:0]           o_ex,
  output logic                        o_of,
  output logic                        o_uf
);

  localparam int W   = SWIDTH + RSWIDTH + 2;
  localparam int NW  = W - 1;                 // hidden + frac + round bits
  localparam int XW  = EWIDTH + 2;            // signed internal exponent
  localparam int LZW = $clog2(NW + 1);
  localparam logic signed [XW-1:0] EXP_INF = XW'((2 ** EWIDTH) - 1);

  logic                  adv;
  logic [2:1]            vld_pipe_d, vld_pipe_q;
  logic [LZW-1:0]        lz;

  logic                  s1_sgn_d, s1_sgn_q, s1_zero_d, s1_zero_q;
  logic [NW-1:0]         s1_sg_d, s1_sg_q;
  logic signed [XW-1:0]  s1_ex_d, s1_ex_q;

  logic [SWIDTH:0]       frac, sg_r;
  logic                  guard, sticky, rnd;
  logic [SWIDTH+1:0]     sum;
  logic signed [XW-1:0]  ex_r;

  logic                  o_sgn_d, o_sgn_q, o_of_d, o_of_q, o_uf_d, o_uf_q;
  logic [SWIDTH:0]       o_sg_d, o_sg_q;
  logic [EWIDTH-1:0]     o_ex_d, o_ex_q;

  assign adv     = !vld_pipe_q[2] || i_ready;
  assign o_ready = adv;
  assign o_valid = vld_pipe_q[2];
  assign o_sgn   = o_sgn_q;
  assign o_sg    = o_sg_q;
  assign o_ex    = o_ex_q;
  assign o_of    = o_of_q;
  assign o_uf    = o_uf_q;

  flp_lzc #(.WIDTH(NW)) u_lzc (
    .i_vec (i_sg[NW-1:0]),
    .o_cnt (lz)
  );

  // Bubbles travel with the beats; nothing is collapsed.
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    if (adv) vld_pipe_d = {vld_pipe_q[1], i_valid};
  end

  // Stage 1: pre-normalize so the hidden bit lands at NW-1.
  always_comb begin
    s1_sgn_d  = s1_sgn_q;
    s1_zero_d = s1_zero_q;
    s1_sg_d   = s1_sg_q;
    s1_ex_d   = s1_ex_q;
    if (adv) begin
      s1_sgn_d  = i_sgn;
      s1_zero_d = (i_sg == '0);
      if (i_sg[W-1]) begin
        // Carry out of the add: the bit shifted out must still count as sticky.
        s1_sg_d = i_sg[W-1:1] | NW'(i_sg[0]);
        s1_ex_d = $signed({2'b00, i_ex}) + XW'(1);
      end else begin
        s1_sg_d = i_sg[NW-1:0] << lz;
        s1_ex_d = $signed({2'b00, i_ex}) - $signed({{(XW-LZW){1'b0}}, lz});
      end
    end
  end

  // Stage 2: round to nearest even, then apply exponent range exceptions.
  always_comb begin
    frac   = s1_sg_q[NW-1:RSWIDTH];
    guard  = s1_sg_q[RSWIDTH-1];
    sticky = |s1_sg_q[RSWIDTH-2:0];
    rnd    = guard && (sticky || frac[0]);
    sum    = {1'b0, frac} + (SWIDTH+2)'(rnd);
    if (sum[SWIDTH+1]) begin
      sg_r = {1'b1, {SWIDTH{1'b0}}};
      ex_r = s1_ex_q + XW'(1);
    end else begin
      sg_r = sum[SWIDTH:0];
      ex_r = s1_ex_q;
    end

    o_sgn_d = o_sgn_q;
    o_sg_d  = o_sg_q;
    o_ex_d  = o_ex_q;
    o_of_d  = o_of_q;
    o_uf_d  = o_uf_q;
    if (adv) begin
      o_sgn_d = s1_sgn_q;
      o_sg_d  = '0;
      o_ex_d  = '0;
      o_of_d  = 1'b0;
      o_uf_d  = 1'b0;
      if (s1_zero_q) begin
        // exact zero: no flags
      end else if (ex_r <= 0) begin
        o_uf_d = 1'b1;
      end else if (ex_r >= EXP_INF) begin
        o_ex_d = '1;
        o_of_d = 1'b1;
      end else begin
        o_sg_d = sg_r;
        o_ex_d = ex_r[EWIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      s1_sgn_q   <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_sg_q    <= '0;
      s1_ex_q    <= '0;
      o_sgn_q    <= 1'b0;
      o_sg_q     <= '0;
      o_ex_q     <= '0;
      o_of_q     <= 1'b0;
      o_uf_q     <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_sgn_q   <= s1_sgn_d;
      s1_zero_q  <= s1_zero_d;
      s1_sg_q    <= s1_sg_d;
      s1_ex_q    <= s1_ex_d;
      o_sgn_q    <= o_sgn_d;
      o_sg_q     <= o_sg_d;
      o_ex_q     <= o_ex_d;
      o_of_q     <= o_of_d;
      o_uf_q     <= o_uf_d;
    end
  end

endmodule
